// File: rtl/regfile_dump.sv
// Streams a contiguous (wrapping) range of register-file entries out over a
// valid/ready port, one word per READ+SEND pair, and reports their sum.
module regfile_dump #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] rd_add,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] rd_hold;
    logic [DATA_W-1:0] acc;
    logic              handshake;

    always_comb begin
        state_nxt = state;
        handshake = 1'b0;
        unique case (state)
            IDLE: if (start && !abort) state_nxt = READ;
            READ: state_nxt = abort ? IDLE : SEND;
            SEND: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    handshake = 1'b1;
                    state_nxt = (cur == last_q) ? DONE : READ;
                end
            end
            DONE: state_nxt = IDLE;
        endcase
    end

    // An abort during DONE suppresses both the pulse and the checksum load.
    assign busy      = (state != IDLE);
    assign out_valid = (state == SEND);
    assign done      = (state == DONE) && !abort;
    assign rd_add    = (state == READ) ? cur : rd_hold;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cur       <= '0;
            last_q    <= '0;
            rd_hold   <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_index <= '0;
            checksum  <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        cur    <= first_reg;
                        last_q <= last_reg;
                        acc    <= '0;
                    end
                end
                READ: begin
                    rd_hold <= cur;
                    if (!abort) begin
                        out_data  <= rd_data;
                        out_index <= cur;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        acc <= acc + out_data;
                        if (cur != last_q) cur <= cur + 1'b1;
                    end
                end
                DONE: begin
                    if (!abort) checksum <= acc;
                end
            endcase
        end
    end

endmodule
